or_result_checker: RTL

Self-checking result stage that sits directly downstream of the `logic_or` unit in the bench environment. It consumes the operands `a`, `b` and the unit's output `y`, and compares `y` against `a | b` over a fixed-length run of `N_SAMPLES` clocked samples. It reports pass/fail, a mismatch count and the index of the first failing sample, so any OR bench can be turned into a self-checking regression.

---
 rtl/or_chk_pkg.sv | 10 +
 rtl/or_result_checker_counter.sv | 27 ++
 rtl/or_result_checker.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/or_chk_pkg.sv
// Shared types and defaults for the OR result checker.
package or_chk_pkg;

    // Run sequencing: IDLE -> RUN (capture) -> DRAIN (last compare) -> DONE.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;

    // Default width of every counter and index output.
    localparam int CNT_W_DEFAULT = 8;

endpackage : or_chk_pkg

// File: rtl/or_result_checker_counter.sv
// Up-counter with synchronous clear and count enable; clear has priority.
module chk_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Count register: async reset, sync clear, then increment on enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule : chk_counter

// File: rtl/or_result_checker.sv
// Compares an OR unit's result y against a | b over a fixed run of samples
// and reports pass/fail, mismatch count and first failing sample index.
module or_result_checker
    import or_chk_pkg::*;
#(
    parameter int N_SAMPLES = 16,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output chk_state_t       dbg_state
);

    // Counters are sized so a legal run can never wrap them.
    if ((N_SAMPLES < 1) || (N_SAMPLES > ((2 ** CNT_W) - 1))) begin : g_bad_param
        $error("or_result_checker: N_SAMPLES out of range for CNT_W");
    end

    chk_state_t       r_state;
    chk_state_t       w_next_state;
    logic             w_clr;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_cap_cnt;
    logic [CNT_W-1:0] w_sample_cnt;
    logic [CNT_W-1:0] w_err_cnt;

    // Stage register: r_stg_valid high means r_stg_{a,b,y} hold one captured
    // sample that is compared (and consumed) on the next rising edge. There is
    // no backpressure; every valid stage entry is compared exactly once.
    logic             r_stg_a;
    logic             r_stg_b;
    logic             r_stg_y;
    logic             r_stg_valid;
    logic             r_first_err_valid;
    logic [CNT_W-1:0] r_first_err_idx;

    // A start accepted in IDLE or DONE wipes every result of the previous run.
    assign w_clr      = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mismatch = r_stg_valid && (r_stg_y != (r_stg_a | r_stg_b));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; RUN ends on the edge that makes the Nth capture.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_cap_cnt == CNT_W'(N_SAMPLES - 1)) w_next_state = DRAIN;
            DRAIN:   w_next_state = DONE;
            DONE:    if (start) w_next_state = RUN;
            default: w_next_state = IDLE;
        endcase
    end

    // Stage register: capture every edge in RUN, empty it in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_a     <= 1'b0;
            r_stg_b     <= 1'b0;
            r_stg_y     <= 1'b0;
            r_stg_valid <= 1'b0;
        end else if (w_clr) begin
            r_stg_a     <= 1'b0;
            r_stg_b     <= 1'b0;
            r_stg_y     <= 1'b0;
            r_stg_valid <= 1'b0;
        end else if (r_state == RUN) begin
            r_stg_a     <= a;
            r_stg_b     <= b;
            r_stg_y     <= y;
            r_stg_valid <= 1'b1;
        end else if (r_state == DRAIN) begin
            r_stg_valid <= 1'b0;
        end
    end

    // First-error capture: latch the pre-increment sample index once per run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
        end else if (w_clr) begin
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
        end else if (w_mismatch && !r_first_err_valid) begin
            r_first_err_valid <= 1'b1;
            r_first_err_idx   <= w_sample_cnt;
        end
    end

    chk_counter #(.W(CNT_W)) u_cap_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_clr),
        .i_en    (r_state == RUN),
        .o_q     (w_cap_cnt)
    );

    chk_counter #(.W(CNT_W)) u_sample_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_clr),
        .i_en    (r_stg_valid),
        .o_q     (w_sample_cnt)
    );

    chk_counter #(.W(CNT_W)) u_err_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_clr),
        .i_en    (w_mismatch),
        .o_q     (w_err_cnt)
    );

    assign busy            = (r_state == RUN) || (r_state == DRAIN);
    assign done            = (r_state == DONE);
    assign pass            = done && (w_err_cnt == '0);
    assign sample_cnt      = w_sample_cnt;
    assign err_cnt         = w_err_cnt;
    assign first_err_valid = r_first_err_valid;
    assign first_err_idx   = r_first_err_idx;
    assign dbg_state       = r_state;

endmodule : or_result_checker
